btn_debouncer_multi: RTL and testbench
======================================

Name: btn_debouncer_multi

Overview:
Multi-channel successor to the single-button debouncer, for the TV-B-Gone front panel and any future keypad.
- One shared sample prescaler drives CHANNELS independent channels.
- Each channel synchronises its raw input, filters it with a configurable stable-sample count, and tracks press state.
- Each channel emits a debounced level plus one-clock press, release, long-press and auto-repeat events.
- Sits between the pad inputs and the mode/transmit control FSM.

Parameters:
CHANNELS, 4, number of button channels (1..16)
CLK_MHZ, 8, clock frequency in MHz
PERIOD_MS, 10, sample period in ms; TICK_CYCLES = CLK_MHZ*PERIOD_MS*1000
STABLE_SAMPLES, 3, consecutive equal samples required to change debounced level (2..15)
LONG_TICKS, 100, ticks held after press before long event (>=1)
REPEAT_TICKS, 20, ticks between repeat events while long-held; 0 disables repeat
ACTIVE_LOW_MASK, '0, CHANNELS-bit mask; bit i=1 means raw input i is pressed when low

Ports:
clock_in  input  1  system clock
reset_n_in  input  1  reset, asynchronous, active-low
enable_in  input  1  1 = sampling runs; 0 = prescaler and channel state frozen, events suppressed
btn_in  input  CHANNELS  raw asynchronous button inputs
level_out  output  CHANNELS  debounced pressed level (1 = pressed)
press_out  output  CHANNELS  one-clock pulse on debounced press
release_out  output  CHANNELS  one-clock pulse on debounced release
long_out  output  CHANNELS  one-clock pulse when hold reaches LONG_TICKS
repeat_out  output  CHANNELS  one-clock pulse every REPEAT_TICKS while in HELD
tick_out  output  1  one-clock pulse at each sample instant (debug/test)

Behaviour:
- Clock and reset: one clock, clock_in; reset is asynchronous and active-low on reset_n_in. While reset_n_in=0:
  - all outputs are 0;
  - prescaler loads TICK_CYCLES-1;
  - synchronisers, sample counters and FSMs clear to IDLE/level 0.
- Deassertion of reset_n_in is synchronised internally through 2 flops before it releases the prescaler.
- Input synchroniser: each btn_in bit passes through 2 flops every clock, regardless of enable. ACTIVE_LOW_MASK inversion is applied after synchronisation, giving the "pressed" sample p.
- Prescaler:
  - down-counter of width $clog2(TICK_CYCLES); it advances only when enable_in=1;
  - tick = (count==0); at a tick it reloads TICK_CYCLES-1;
  - the first tick after reset falls TICK_CYCLES enabled clocks after release.
- Filter, at each tick, per channel:
  - if p != level, the stable counter increments; otherwise it clears;
  - when the counter reaches STABLE_SAMPLES-1 and p != level still holds, level toggles and the counter clears;
  - a glitch shorter than STABLE_SAMPLES ticks never changes level.
- Per-channel FSM (advances only on tick):
  - IDLE: level rises -> PRESSED, hold counter = 0, press pulse.
  - PRESSED: level falls -> IDLE, release pulse; otherwise the hold counter increments; when it reaches LONG_TICKS -> HELD, long pulse, hold counter = 0.
  - HELD: level falls -> IDLE, release pulse; otherwise, if REPEAT_TICKS>0, the hold counter increments and a repeat pulse fires each time it reaches REPEAT_TICKS, after which it wraps to 0.
- Event timing:
  - all event outputs are registered and asserted for exactly one clock, in the cycle after the tick edge that caused them;
  - level_out changes on the same edge;
  - end-to-end press latency is 2 clocks of synchronisation plus STABLE_SAMPLES ticks (bounded within 1 tick).
- Event exclusivity:
  - release has priority: a channel never asserts long or repeat in the same cycle as release;
  - long and repeat are never asserted together.
- Channels are fully independent; simultaneous events on different channels all appear in the same cycle.
- enable_in=0 mid-hold: counters freeze and resume on re-enable; no events are lost or duplicated.
- Hold counter width is $clog2(max(LONG_TICKS,REPEAT_TICKS)+1); it never overflows.
- Asynchronous reset mid-hold returns to IDLE with no release pulse.

Decomposition:
- Package btn_pkg:
  - typedef enum btn_state_e {BTN_IDLE, BTN_PRESSED, BTN_HELD};
  - function tick_cycles(clk_mhz, period_ms).
- Sub-module btn_channel holds the synchroniser, filter, FSM and event registers, with a shared tick input. The top instantiates CHANNELS copies in a generate loop and holds the prescaler and reset synchroniser.

Test Plan:
Bench configuration for all scenarios: CLK_MHZ=1, PERIOD_MS=1 (tick every 1000 clocks), STABLE_SAMPLES=3, LONG_TICKS=5, REPEAT_TICKS=2, CHANNELS=4.
- Clean press on ch0, held 4 ticks, then released -> press_out[0] pulses once about 3 ticks after the edge; level_out[0]=1; release_out[0] pulses once 3 ticks after release; no long pulse.
- Ch1 bounces with 1-tick-wide pulses for 10 ticks -> level_out[1] stays 0 and no events fire.
- Ch2 held 12 ticks after press -> long_out[2] at hold tick 5, repeat_out[2] at ticks 7, 9 and 11, one release pulse on release, no repeat in the release cycle.
- ACTIVE_LOW_MASK=4'b1000 with ch3 idle high, then driven low -> press_out[3] fires; the driven-high idle period produces no event.
- ch0 and ch1 pressed on the same clock -> press_out=4'b0011 in a single cycle.
- reset_n_in pulsed low for 3 clocks mid-HELD on ch2 -> all outputs go to 0 immediately and asynchronously; no release pulse; with the input still held, press re-fires STABLE_SAMPLES ticks after reset.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared state type and prescaler helper for the button debouncer
package btn_pkg;
  typedef enum logic [1:0] {BTN_IDLE, BTN_PRESSED, BTN_HELD} btn_state_e;
  function automatic int tick_cycles(input int clk_mhz, input int period_ms);
    return clk_mhz * period_ms * 1000;
  endfunction
endpackage

// File: rtl/btn_channel.sv
// btn_channel: input synchroniser, stable-count filter and press/hold event FSM for one button
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_SAMPLES = 3,
  parameter int LONG_TICKS = 100,
  parameter int REPEAT_TICKS = 20,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic tick_in,
  input  logic btn_in,
  output logic level_out,
  output logic press_out,
  output logic release_out,
  output logic long_out,
  output logic repeat_out
);
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int SW = $clog2(STABLE_SAMPLES);
  btn_state_e state, state_nx;
  logic [1:0] sync;
  logic [SW-1:0] stab, stab_nx;
  logic [HW-1:0] hold, hold_nx, hold_inc;
  logic p, level_nx, press_nx, release_nx, long_nx, repeat_nx;
  assign p = sync[1] ^ ACTIVE_LOW;
  assign hold_inc = hold + 1'b1;
  always_comb begin
    stab_nx = stab;
    level_nx = level_out;
    state_nx = state;
    hold_nx = hold;
    press_nx = 1'b0;
    release_nx = 1'b0;
    long_nx = 1'b0;
    repeat_nx = 1'b0;
    if (tick_in) begin
      stab_nx = (p == level_out || stab == SW'(STABLE_SAMPLES - 1)) ? '0 : stab + 1'b1;
      level_nx = (p != level_out && stab == SW'(STABLE_SAMPLES - 1)) ? p : level_out;
      // IDLE holds exactly while the filtered level is 0, so a rise can only be seen there
      unique case (state)
        BTN_IDLE: if (level_nx) begin
          state_nx = BTN_PRESSED;
          hold_nx = '0;
          press_nx = 1'b1;
        end
        BTN_PRESSED: if (!level_nx) begin
          state_nx = BTN_IDLE;
          release_nx = 1'b1;
        end else if (hold_inc == HW'(LONG_TICKS)) begin
          state_nx = BTN_HELD;
          hold_nx = '0;
          long_nx = 1'b1;
        end else hold_nx = hold_inc;
        BTN_HELD: if (!level_nx) begin
          state_nx = BTN_IDLE;
          release_nx = 1'b1;
        end else if (REPEAT_TICKS > 0) begin
          repeat_nx = hold_inc == HW'(REPEAT_TICKS);
          hold_nx = repeat_nx ? '0 : hold_inc;
        end
        default: state_nx = BTN_IDLE;
      endcase
    end
  end
  always_ff @(posedge clock_in or negedge reset_n_in)
    if (!reset_n_in) begin
      sync <= '0;
      stab <= '0;
      hold <= '0;
      state <= BTN_IDLE;
      level_out <= 1'b0;
      press_out <= 1'b0;
      release_out <= 1'b0;
      long_out <= 1'b0;
      repeat_out <= 1'b0;
    end else begin
      sync <= {sync[0], btn_in};
      stab <= stab_nx;
      hold <= hold_nx;
      state <= state_nx;
      level_out <= level_nx;
      press_out <= press_nx;
      release_out <= release_nx;
      long_out <= long_nx;
      repeat_out <= repeat_nx;
    end
endmodule

// File: rtl/btn_debouncer_multi.sv
// btn_debouncer_multi: shared sample prescaler and reset synchroniser driving CHANNELS button channels
module btn_debouncer_multi
  import btn_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CLK_MHZ = 8,
  parameter int PERIOD_MS = 10,
  parameter int STABLE_SAMPLES = 3,
  parameter int LONG_TICKS = 100,
  parameter int REPEAT_TICKS = 20,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0
) (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic enable_in,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_out,
  output logic [CHANNELS-1:0] release_out,
  output logic [CHANNELS-1:0] long_out,
  output logic [CHANNELS-1:0] repeat_out,
  output logic tick_out
);
  localparam int TICK_CYCLES = tick_cycles(CLK_MHZ, PERIOD_MS);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  logic [1:0] rst_sync;
  logic [CW-1:0] count;
  assign tick_out = rst_sync[1] & enable_in & (count == '0);
  // prescaler stays parked at its reload value until the synchronised reset release
  always_ff @(posedge clock_in or negedge reset_n_in)
    if (!reset_n_in) begin
      rst_sync <= '0;
      count <= CW'(TICK_CYCLES - 1);
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
      if (rst_sync[1] && enable_in) count <= tick_out ? CW'(TICK_CYCLES - 1) : count - 1'b1;
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .LONG_TICKS(LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .ACTIVE_LOW(ACTIVE_LOW_MASK[i])
    ) u_ch (
      .clock_in(clock_in),
      .reset_n_in(reset_n_in),
      .tick_in(tick_out),
      .btn_in(btn_in[i]),
      .level_out(level_out[i]),
      .press_out(press_out[i]),
      .release_out(release_out[i]),
      .long_out(long_out[i]),
      .repeat_out(repeat_out[i])
    );
  end
endmodule

// File: tb/tb_btn_debouncer_multi.sv
// tb_btn_debouncer_multi: scoreboard bench, expected events queued with their cycle as stimulus is driven
module tb_btn_debouncer_multi;
  localparam int P = 1000;
  localparam logic [3:0] NIL = 4'b0;
  typedef struct {int cyc; logic [15:0] ev;} exp_t;
  logic clock_in = 1'b0;
  logic reset_n_in = 1'b0;
  logic enable_in = 1'b0;
  logic [3:0] btn_in = 4'b1000;
  logic [3:0] level_out, press_out, release_out, long_out, repeat_out;
  logic tick_out;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rel;
  exp_t q[$];
  btn_debouncer_multi #(
    .CHANNELS(4), .CLK_MHZ(1), .PERIOD_MS(1), .STABLE_SAMPLES(3),
    .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW_MASK(4'b1000)
  ) dut (
    .clock_in(clock_in),
    .reset_n_in(reset_n_in),
    .enable_in(enable_in),
    .btn_in(btn_in),
    .level_out(level_out),
    .press_out(press_out),
    .release_out(release_out),
    .long_out(long_out),
    .repeat_out(repeat_out),
    .tick_out(tick_out)
  );
  always #5 clock_in = ~clock_in;
  always @(posedge clock_in) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at cycle %0d", tag, got, want, cyc);
    end
  endtask
  function automatic logic [15:0] ev(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l, input logic [3:0] rp);
    return {p, r, l, rp};
  endfunction
  task automatic push(input int c, input logic [15:0] e);
    q.push_back('{cyc: c, ev: e});
  endtask
  task automatic ticks(input int n);
    repeat (n * P) @(negedge clock_in);
  endtask
  always @(negedge clock_in) begin
    if (q.size() > 0 && cyc > q[0].cyc) begin
      chk("missed_event", cyc, q[0].cyc);
      q.delete(0);
    end
    if (|{press_out, release_out, long_out, repeat_out}) begin
      if (q.size() == 0) chk("unexpected_event", {press_out, release_out, long_out, repeat_out}, 0);
      else begin
        chk("event_cycle", cyc, q[0].cyc);
        chk("event_bits", {press_out, release_out, long_out, repeat_out}, q[0].ev);
        q.delete(0);
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clock_in);
    chk("rst_level", level_out, 0);
    chk("rst_outputs", {press_out, release_out, long_out, repeat_out, tick_out}, 0);
    enable_in = 1'b1;
    reset_n_in = 1'b1;
    repeat (P) @(negedge clock_in);
    chk("tick_before_first", tick_out, 0);
    @(negedge clock_in);
    chk("tick_first", tick_out, 1);
    @(negedge clock_in);
    chk("tick_after_first", tick_out, 0);
    btn_in[0] = 1'b1;
    push(cyc + 3 * P, ev(4'b0001, NIL, NIL, NIL));
    push(cyc + 7 * P, ev(NIL, 4'b0001, NIL, NIL));
    ticks(3);
    chk("s1_level_hi", level_out, 4'b0001);
    ticks(1);
    btn_in[0] = 1'b0;
    ticks(3);
    chk("s1_level_lo", level_out, 0);
    btn_in[3] = 1'b0;
    push(cyc + 3 * P, ev(4'b1000, NIL, NIL, NIL));
    push(cyc + 6 * P, ev(NIL, 4'b1000, NIL, NIL));
    for (int k = 0; k < 10; k++) begin
      btn_in[1] = ~btn_in[1];
      ticks(1);
      if (k == 2) begin
        chk("s4_level_hi", level_out, 4'b1000);
        btn_in[3] = 1'b1;
      end
    end
    chk("s2_bounce_level", level_out, 0);
    btn_in[2] = 1'b1;
    push(cyc + 3 * P, ev(4'b0100, NIL, NIL, NIL));
    ticks(4);
    chk("s3_level_hi", level_out, 4'b0100);
    enable_in = 1'b0;
    repeat (P / 2) @(negedge clock_in);
    enable_in = 1'b1;
    push(cyc + 4 * P, ev(NIL, NIL, 4'b0100, NIL));
    push(cyc + 6 * P, ev(NIL, NIL, NIL, 4'b0100));
    push(cyc + 8 * P, ev(NIL, NIL, NIL, 4'b0100));
    push(cyc + 10 * P, ev(NIL, NIL, NIL, 4'b0100));
    push(cyc + 12 * P, ev(NIL, 4'b0100, NIL, NIL));
    ticks(9);
    btn_in[2] = 1'b0;
    ticks(3);
    chk("s3_level_lo", level_out, 0);
    btn_in[1:0] = 2'b11;
    push(cyc + 3 * P, ev(4'b0011, NIL, NIL, NIL));
    ticks(3);
    chk("s5_level_hi", level_out, 4'b0011);
    btn_in[1:0] = 2'b00;
    push(cyc + 3 * P, ev(NIL, 4'b0011, NIL, NIL));
    ticks(3);
    btn_in[2] = 1'b1;
    push(cyc + 3 * P, ev(4'b0100, NIL, NIL, NIL));
    push(cyc + 8 * P, ev(NIL, NIL, 4'b0100, NIL));
    ticks(8);
    repeat (100) @(negedge clock_in);
    chk("s6_held_level", level_out, 4'b0100);
    #2 reset_n_in = 1'b0;
    #1;
    chk("s6_async_level", level_out, 0);
    chk("s6_async_outputs", {press_out, release_out, long_out, repeat_out, tick_out}, 0);
    chk("s6_queue_before_reset", q.size(), 0);
    repeat (3) @(negedge clock_in);
    reset_n_in = 1'b1;
    rel = cyc;
    push(rel + 2 + 3 * P, ev(4'b0100, NIL, NIL, NIL));
    repeat (P + 2) @(negedge clock_in);
    ticks(2);
    chk("s6_repress_level", level_out, 4'b0100);
    btn_in[2] = 1'b0;
    push(cyc + 3 * P, ev(NIL, 4'b0100, NIL, NIL));
    ticks(3);
    repeat (10) @(negedge clock_in);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
